// File: rtl/xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder
//
// Stand-in for the XADC primitive as seen over its Dynamic Reconfiguration
// Port. It holds a small DRP register file, answers every accepted DEN with a
// one-cycle DRDY a fixed number of cycles later, and runs a continuous
// conversion sequence over aux channels 0-3. The sample values come from the
// aux_sample stimulus bus.
//
// Ports:
//   clk          DRP clock (DCLK)
//   rst          asynchronous, active-high reset
//   DADDR        DRP register address
//   DEN          one-cycle pulse that starts a transaction
//   DI           write data
//   DWE          write enable, qualified by DEN
//   aux_sample   stimulus; aux channel i sits at bits [16i+15:16i]
//   DO           read data; non-zero only in the DRDY cycle of a read
//   DRDY         transaction-complete pulse
//   BUSY         conversion in progress
//   EOC          end-of-conversion pulse
//   EOS          end-of-sequence pulse (with EOC on the highest enabled channel)
//   CHANNEL      channel of the last completed conversion (0x10 + i)
//   drp_overlap  sticky flag: DEN arrived while a transaction was in flight
//
// Handshake: the requester pulses DEN for one cycle. DADDR/DWE/DI are captured
// in that cycle. DRDY is high for exactly one cycle, DRDY_LATENCY cycles after
// the DEN cycle. Only one transaction can be outstanding. A DEN that arrives
// before the DRDY cycle has ended is dropped and sets drp_overlap.
// -----------------------------------------------------------------------------
module xadc_drp_responder #(
  parameter int DRDY_LATENCY = 4,
  parameter int CONV_CYCLES  = 26,
  parameter int NUM_AUX      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic [15:0] DI,
  input  logic        DWE,
  input  logic [63:0] aux_sample,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOC,
  output logic        EOS,
  output logic [4:0]  CHANNEL,
  output logic        drp_overlap
);

  // The WAIT state covers DRDY_LATENCY-1 cycles. The counter reaches zero in
  // the last of them.
  localparam logic [3:0] WAIT_LOAD = 4'(DRDY_LATENCY - 2);
  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_RESP = 2'd2
  } drp_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EOC  = 2'd2
  } seq_state_t;

  drp_state_t  drp_state;
  seq_state_t  seq_state;

  // Register file: cfg_q covers 0x40-0x4F; stat_q covers 0x10-0x13.
  logic [15:0] cfg_q  [16];
  logic [15:0] stat_q [NUM_AUX];

  // Latched DRP transaction.
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic [3:0]  wait_cnt;
  logic [15:0] rd_data;

  // Conversion engine. conv_ch doubles as "last channel converted". Its
  // reset value of 3 makes the first conversion land on channel 0.
  logic [1:0]  conv_ch;
  logic [3:0]  conv_mask;
  logic [7:0]  conv_cnt;
  logic        seq_en;
  logic [3:0]  cfg_mask;
  logic [15:0] aux_sel;

  assign cfg_mask = cfg_q[9][3:0];
  assign seq_en   = (cfg_q[1][15:12] == 4'h2) && (cfg_mask != 4'h0);
  assign aux_sel  = aux_sample[{conv_ch, 4'b0000} +: 16];

  // Next enabled channel strictly after 'last', ascending with wrap. If only
  // 'last' itself is enabled, it is picked again.
  function automatic logic [1:0] next_ch(input logic [1:0] last,
                                         input logic [3:0] mask);
    logic [1:0] c;
    next_ch = last;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      if (mask[c]) next_ch = c;
    end
  endfunction

  function automatic logic [1:0] top_ch(input logic [3:0] mask);
    top_ch = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) top_ch = 2'(k);
    end
  endfunction

  // Read mux on the latched address. It uses register values from before the
  // current edge, so a same-edge status update is not visible.
  always_comb begin
    rd_data = 16'h0000;
    if (addr_q[6:4] == 3'b100) begin
      rd_data = cfg_q[addr_q[3:0]];
    end else if (addr_q[6:2] == 5'b00100) begin
      rd_data = stat_q[addr_q[1:0]];
    end
  end

  // DRP transaction FSM plus the configuration registers it writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drp_state   <= D_IDLE;
      addr_q      <= 7'h00;
      we_q        <= 1'b0;
      di_q        <= 16'h0000;
      wait_cnt    <= 4'h0;
      DO          <= 16'h0000;
      DRDY        <= 1'b0;
      drp_overlap <= 1'b0;
      for (int i = 0; i < 16; i++) cfg_q[i] <= 16'h0000;
      cfg_q[1]    <= 16'h2000;
      cfg_q[2]    <= 16'h0400;
      cfg_q[9]    <= 16'h000F;
    end else begin
      case (drp_state)
        D_IDLE: begin
          if (DEN) begin
            addr_q    <= DADDR;
            we_q      <= DWE;
            di_q      <= DI;
            wait_cnt  <= WAIT_LOAD;
            drp_state <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (DEN) drp_overlap <= 1'b1;
          if (wait_cnt == 4'h0) begin
            drp_state <= D_RESP;
            DRDY      <= 1'b1;
            DO        <= we_q ? 16'h0000 : rd_data;
            // Only 0x40-0x4F are writable. Any other write completes
            // normally and is discarded.
            if (we_q && (addr_q[6:4] == 3'b100)) begin
              cfg_q[addr_q[3:0]] <= di_q;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'h1;
          end
        end
        D_RESP: begin
          if (DEN) drp_overlap <= 1'b1;
          DRDY      <= 1'b0;
          DO        <= 16'h0000;
          drp_state <= D_IDLE;
        end
        default: begin
          drp_state <= D_IDLE;
          DRDY      <= 1'b0;
          DO        <= 16'h0000;
        end
      endcase
    end
  end

  // Conversion sequencer plus the status registers it writes. The config is
  // sampled only when a conversion starts. A conversion already in flight
  // always completes, using the mask it started with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_state <= S_IDLE;
      conv_ch   <= 2'd3;
      conv_mask <= 4'h0;
      conv_cnt  <= 8'h00;
      BUSY      <= 1'b0;
      EOC       <= 1'b0;
      EOS       <= 1'b0;
      CHANNEL   <= 5'h00;
      for (int i = 0; i < NUM_AUX; i++) stat_q[i] <= 16'h0000;
    end else begin
      case (seq_state)
        S_IDLE: begin
          if (seq_en) begin
            conv_ch   <= next_ch(conv_ch, cfg_mask);
            conv_mask <= cfg_mask;
            conv_cnt  <= CONV_LOAD;
            BUSY      <= 1'b1;
            seq_state <= S_CONV;
          end
        end
        S_CONV: begin
          if (conv_cnt == 8'h00) begin
            BUSY      <= 1'b0;
            EOC       <= 1'b1;
            EOS       <= (conv_ch == top_ch(conv_mask));
            CHANNEL   <= {3'b100, conv_ch};
            seq_state <= S_EOC;
          end else begin
            conv_cnt <= conv_cnt - 8'h01;
          end
        end
        S_EOC: begin
          EOC <= 1'b0;
          EOS <= 1'b0;
          // The sample is taken in the EOC cycle and left-justified to
          // 12 bits.
          stat_q[conv_ch] <= aux_sel & 16'hFFF0;
          if (seq_en) begin
            conv_ch   <= next_ch(conv_ch, cfg_mask);
            conv_mask <= cfg_mask;
            conv_cnt  <= CONV_LOAD;
            BUSY      <= 1'b1;
            seq_state <= S_CONV;
          end else begin
            seq_state <= S_IDLE;
          end
        end
        default: begin
          seq_state <= S_IDLE;
          BUSY      <= 1'b0;
          EOC       <= 1'b0;
          EOS       <= 1'b0;
        end
      endcase
    end
  end

endmodule
